imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

- Pipelined immediate-generation stage between fetch and decode.
- Accepts raw 32-bit instructions over a valid/ready handshake.
- Classifies the immediate format from the opcode itself, with no external control.
- Produces a sign- or zero-extended XLEN-bit immediate, a format code and an illegal-opcode flag, one cycle later, with an optional skid buffer for full throughput under backpressure.

## Interface
- XLEN, default 32: datapath width; legal values 32 or 64.
- TAG_W, default 8: width of the sideband tag carried alongside each instruction.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous and active-high.
- in_valid_i  input  1  instruction present.
- in_ready_o  output  1  stage can accept.
- in_instr_i  input  32  raw instruction.
- in_tag_i  input  TAG_W  sideband, passed through unchanged.
- out_valid_o  output  1  result present.
- out_ready_i  input  1  consumer accepts.
- out_imm_o  output  XLEN  extended immediate.
- out_type_o  output  3  format code: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
- out_illegal_o  output  1  opcode not recognised.
- out_tag_o  output  TAG_W  tag of the current result.

## Operation
- Transfers:
  - An input transfer occurs when in_valid_i && in_ready_o.
  - An output transfer occurs when out_valid_o && out_ready_i.
- Classification by opcode = in_instr_i[6:0]:
  - 0110111 (LUI) and 0010111 (AUIPC): U.
  - 1101111 (JAL): J.
  - 1100111 (JALR), 0000011 (LOAD), 0010011 (OP-IMM), 0001111 (MISC-MEM): I.
  - 0100011 (STORE): S.
  - 1100011 (BRANCH): B.
  - 1110011 (SYSTEM): Z when funct3[2]=1, otherwise I.
  - 0110011 (OP): NONE.
  - 0011011 (OP-IMM-32): I when XLEN=64; illegal when XLEN=32.
  - 0111011 (OP-32): NONE when XLEN=64; illegal when XLEN=32.
  - Any other opcode: out_illegal_o=1, out_type_o=NONE, out_imm_o=0.
- Immediate formation (instruction bit 31 is the sign bit):
  - I: sign-extend instr[31:20].
  - S: sign-extend {instr[31:25], instr[11:7]}.
  - B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
  - J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Z: zero-extend instr[19:15] (CSR zimm).
  - NONE: 0.
- Ordering:
  - Results leave in acceptance order.
  - Each accepted instruction produces exactly one output transfer; nothing is dropped or duplicated.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on the out_* ports after edge N.
- Throughput is 1 instruction per cycle while out_ready_i=1.
- Output stability: while out_valid_o=1 && out_ready_i=0, all out_* ports hold stable.
- Reset values, held while rst_i=1:
  - out_valid_o=0, out_imm_o=0, out_type_o=0, out_illegal_o=0, out_tag_o=0.
  - in_ready_o=0.
  - in_ready_o=1 from the first cycle after deassertion.
- Reset mid-operation discards all held entries immediately; no output transfer follows.
- Simultaneous accept and drain on one edge, main register full: the new entry replaces the drained one, with no bubble.

## Configuration
- IMM_GEN_SKID_EN defined:
  - Two entries: main output register plus one skid register.
  - in_ready_o is a registered signal equal to !skid_full, with no combinational path from out_ready_i.
  - When out_ready_i drops, one further input is captured in the skid register and in_ready_o falls on the next cycle.
  - On drain, the skid entry moves to the main register first.
- IMM_GEN_SKID_EN undefined:
  - Single output register.
  - in_ready_o = !out_valid_o || out_ready_i, computed combinationally.
  - Identical data behaviour and 1-cycle latency.

## Test plan
- 0xFFF00093 (addi x1,x0,-1), XLEN=32 -> next cycle out_imm_o=0xFFFFFFFF, type=1, illegal=0.
- 0xFE112E23 (sw x1,-4(x2)) -> out_imm_o=0xFFFFFFFC, type=2.
- 0xFE000EE3 (beq -4) -> out_imm_o=0xFFFFFFFC, type=3.
- Back-to-back 0x300FD073 (csrrwi zimm=31) and 0x0000007F:
  - First result: imm=0x0000001F, type=6.
  - Second result: illegal=1, imm=0, type=0.
- U-type sign extension:
  - 0x123450B7 (lui) -> out_imm_o=0x12345000, type=4.
  - XLEN=64, 0x800000B7 -> out_imm_o=0xFFFFFFFF80000000.
- Backpressure and reset:
  - Setup: stream 8 tags 0..7 with in_valid_i=1 continuously, holding out_ready_i=0 for cycles 2-5.
  - Required: out_tag_o sequence 0..7 exactly once each.
  - Required: in_ready_o low within 1 cycle (skid) or same cycle (no skid).
  - Assert rst_i mid-stream: out_valid_o=0 immediately and no stale tag appears afterwards.

Source files
------------

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: classifies a raw instruction and forms its immediate, format code and illegal flag (IMM_GEN_SKID_EN selects the skid buffer).
// Latency: 1 cycle from input transfer to the out_* ports.
// Backpressure: with IMM_GEN_SKID_EN, one skid entry and a registered in_ready_o; otherwise in_ready_o = !out_valid_o || out_ready_i.
module imm_gen_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      in_instr_i,
   input  logic [TAG_W-1:0] in_tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  out_imm_o,
   output logic [2:0]       out_type_o,
   output logic             out_illegal_o,
   output logic [TAG_W-1:0] out_tag_o
);

   localparam logic [2:0] T_NONE = 3'd0;
   localparam logic [2:0] T_I    = 3'd1;
   localparam logic [2:0] T_S    = 3'd2;
   localparam logic [2:0] T_B    = 3'd3;
   localparam logic [2:0] T_U    = 3'd4;
   localparam logic [2:0] T_J    = 3'd5;
   localparam logic [2:0] T_Z    = 3'd6;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [2:0]       typ;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } res_t;

   logic [6:0]  opcode;
   logic [2:0]  dec_typ;
   logic        dec_illegal;
   logic [31:0] imm32;
   res_t        dec;
   res_t        main_q;
   logic        main_vld_q;
   logic        in_fire;
   logic        out_fire;

   assign opcode = in_instr_i[6:0];

   // Format classification straight from the opcode; RV64-only opcodes are illegal on a 32-bit datapath.
   always_comb begin
      dec_typ     = T_NONE;
      dec_illegal = 1'b0;
      case (opcode)
         7'b0110111, 7'b0010111:                       dec_typ = T_U;
         7'b1101111:                                   dec_typ = T_J;
         7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: dec_typ = T_I;
         7'b0100011:                                   dec_typ = T_S;
         7'b1100011:                                   dec_typ = T_B;
         7'b1110011:                                   dec_typ = in_instr_i[14] ? T_Z : T_I;
         7'b0110011:                                   dec_typ = T_NONE;
         7'b0011011: begin
            if (XLEN == 64) dec_typ = T_I;
            else            dec_illegal = 1'b1;
         end
         7'b0111011: begin
            if (XLEN != 64) dec_illegal = 1'b1;
         end
         default:                                      dec_illegal = 1'b1;
      endcase
   end

   // 32-bit immediate per format; Z keeps bit 31 clear so the later sign extension zero-extends it.
   always_comb begin
      imm32 = 32'd0;
      case (dec_typ)
         T_I:     imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
         T_S:     imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
         T_B:     imm32 = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                           in_instr_i[30:25], in_instr_i[11:8], 1'b0};
         T_U:     imm32 = {in_instr_i[31:12], 12'd0};
         T_J:     imm32 = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                           in_instr_i[20], in_instr_i[30:21], 1'b0};
         T_Z:     imm32 = {27'd0, in_instr_i[19:15]};
         default: imm32 = 32'd0;
      endcase
   end

   // Pack the decoded result; illegal opcodes leave type NONE and a zero immediate.
   always_comb begin
      dec         = '0;
      dec.imm     = XLEN'($signed(imm32));
      dec.typ     = dec_typ;
      dec.illegal = dec_illegal;
      dec.tag     = in_tag_i;
   end

   assign in_fire  = in_valid_i && in_ready_o;
   assign out_fire = main_vld_q && out_ready_i;

`ifdef IMM_GEN_SKID_EN
   res_t skid_q;
   logic skid_vld_q;
   logic rdy_q;

   assign in_ready_o = rdy_q;

   // Main plus skid entry; the skid drains into main before any new input is taken.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_q     <= '0;
         main_vld_q <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         if (skid_vld_q) begin
            if (out_fire) begin
               main_q     <= skid_q;
               skid_vld_q <= 1'b0;
            end
         end else if (in_fire) begin
            if (!main_vld_q || out_fire) begin
               main_q     <= dec;
               main_vld_q <= 1'b1;
            end else begin
               skid_q     <= dec;
               skid_vld_q <= 1'b1;
            end
         end else if (out_fire) begin
            main_vld_q <= 1'b0;
         end
         // Ready tracks the next-cycle skid occupancy, so it never depends on out_ready_i combinationally.
         rdy_q <= skid_vld_q ? out_fire : !(in_fire && main_vld_q && !out_fire);
      end
   end
`else
   logic alive_q;

   // Holds ready low during reset and releases it on the first edge afterwards.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) alive_q <= 1'b0;
      else       alive_q <= 1'b1;
   end

   assign in_ready_o = alive_q && (!main_vld_q || out_ready_i);

   // Single output register: load on accept (also when draining the same edge), clear on a lone drain.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_q     <= '0;
         main_vld_q <= 1'b0;
      end else if (in_fire) begin
         main_q     <= dec;
         main_vld_q <= 1'b1;
      end else if (out_fire) begin
         main_vld_q <= 1'b0;
      end
   end
`endif

   assign out_valid_o   = main_vld_q;
   assign out_imm_o     = main_q.imm;
   assign out_type_o    = main_q.typ;
   assign out_illegal_o = main_q.illegal;
   assign out_tag_o     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed vectors against a 32-bit and a 64-bit instance sharing one input stream.
// Latency: results are sampled on the falling edge after the accepting rising edge.
// Backpressure: a stall window checks ordering, hold-stable outputs and reset flush.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = 32'd0;
   logic [7:0]  in_tag = 8'd0;
   logic        out_ready = 1'b1;

   logic        in_ready,  out_valid,  out_illegal;
   logic [31:0] out_imm;
   logic [2:0]  out_type;
   logic [7:0]  out_tag;

   logic        in_ready64, out_valid64, out_illegal64;
   logic [63:0] out_imm64;
   logic [2:0]  out_type64;
   logic [7:0]  out_tag64;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   imm_gen_stage #(.XLEN(32), .TAG_W(8)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr), .in_tag_i(in_tag),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_imm_o(out_imm),
      .out_type_o(out_type), .out_illegal_o(out_illegal), .out_tag_o(out_tag)
   );

   imm_gen_stage #(.XLEN(64), .TAG_W(8)) u_dut64 (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready64), .in_instr_i(in_instr), .in_tag_i(in_tag),
      .out_valid_o(out_valid64), .out_ready_i(out_ready), .out_imm_o(out_imm64),
      .out_type_o(out_type64), .out_illegal_o(out_illegal64), .out_tag_o(out_tag64)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [31:0] i32;
      logic [2:0]  t32;
      logic        l32;
      logic [63:0] i64;
      logic [2:0]  t64;
      logic        l64;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent, got, cyc;
      logic hold_prev;
      logic [7:0]  prev_tag;
      logic [31:0] prev_imm;

      vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
      vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0};
      vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0};
      vecs[3]  = '{32'h300FD073, 32'h0000001F, 3'd6, 1'b0, 64'h00000000_0000001F, 3'd6, 1'b0};
      vecs[4]  = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0,                 3'd0, 1'b1};
      vecs[5]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0, 64'h00000000_12345000, 3'd4, 1'b0};
      vecs[6]  = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
      vecs[7]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd5, 1'b0};
      vecs[8]  = '{32'h0040006F, 32'h00000004, 3'd5, 1'b0, 64'h00000000_00000004, 3'd5, 1'b0};
      vecs[9]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'h0,                 3'd0, 1'b0};
      vecs[10] = '{32'hFFF0809B, 32'h00000000, 3'd0, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
      vecs[11] = '{32'h0020803B, 32'h00000000, 3'd0, 1'b1, 64'h0,                 3'd0, 1'b0};
      vecs[12] = '{32'h34011073, 32'h00000340, 3'd1, 1'b0, 64'h00000000_00000340, 3'd1, 1'b0};
      vecs[13] = '{32'h80002083, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFF800, 3'd1, 1'b0};
      vecs[14] = '{32'h0FF0000F, 32'h000000FF, 3'd1, 1'b0, 64'h00000000_000000FF, 3'd1, 1'b0};
      vecs[15] = '{32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0, 64'hFFFFFFFF_FFFFF000, 3'd4, 1'b0};
      vecs[16] = '{32'h00112423, 32'h00000008, 3'd2, 1'b0, 64'h00000000_00000008, 3'd2, 1'b0};

      // Reset state held while rst is high.
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_imm", out_imm, 0);
      check("rst_out_type", out_type, 0);
      check("rst_out_illegal", out_illegal, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_out_valid64", out_valid64, 0);
      check("rst_in_ready64", in_ready64, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);

      // Back-to-back directed vectors, consumer always ready.
      for (int i = 0; i <= NV; i++) begin
         if (i > 0) begin
            #1;
            check($sformatf("v%0d_valid", i-1), out_valid, 1);
            check($sformatf("v%0d_imm32", i-1), out_imm, vecs[i-1].i32);
            check($sformatf("v%0d_type32", i-1), out_type, vecs[i-1].t32);
            check($sformatf("v%0d_ill32", i-1), out_illegal, vecs[i-1].l32);
            check($sformatf("v%0d_tag", i-1), out_tag, 8'(i-1));
            check($sformatf("v%0d_imm64", i-1), out_imm64, vecs[i-1].i64);
            check($sformatf("v%0d_type64", i-1), out_type64, vecs[i-1].t64);
            check($sformatf("v%0d_ill64", i-1), out_illegal64, vecs[i-1].l64);
         end
         if (i < NV) begin
            check($sformatf("v%0d_in_ready", i), in_ready, 1);
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_tag   = 8'(i);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      #1;
      check("idle_out_valid", out_valid, 0);

      // Stream tags 0..7 with a stall window on cycles 2-5.
      sent = 0; got = 0; cyc = 0; hold_prev = 1'b0; prev_tag = 8'd0; prev_imm = 32'd0;
      while (got < 8 && cyc < 60) begin
         @(negedge clk);
         out_ready = !(cyc >= 2 && cyc <= 5);
         in_valid  = (sent < 8);
         in_instr  = (32'(sent) << 20) | 32'h00000093;
         in_tag    = 8'(sent);
         #1;
         if (hold_prev) begin
            check("stall_hold_tag", out_tag, prev_tag);
            check("stall_hold_imm", out_imm, prev_imm);
         end
         if (cyc == 3) check("stall_in_ready_low", in_ready, 0);
         if (out_valid && out_ready) begin
            check("stream_tag", out_tag, 8'(got));
            check("stream_imm", out_imm, 32'(got));
            got++;
         end
         hold_prev = out_valid && !out_ready;
         prev_tag  = out_tag;
         prev_imm  = out_imm;
         if (in_valid && in_ready) sent++;
         cyc++;
      end
      check("stream_all_received", got, 8);
      check("stream_all_sent", sent, 8);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("stream_no_duplicate", out_valid, 0);

      // Reset mid-stream with entries held under backpressure.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_instr = 32'h00100093;
         in_tag   = 8'hA0 + 8'(k);
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      check("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_tag", out_tag, 0);
      check("mid_rst_in_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         check("post_rst_no_stale", out_valid, 0);
         if (k == 0) check("post_rst_ready_again", in_ready, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
